// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with run/pause control and a prescaler.
// OUT counts down with borrow across digits and stops at zero with a one-cycle DONE pulse.
module bcd_down_timer #(
   parameter int DIGITS   = 2,
   parameter int PRESCALE = 1,
   localparam int W       = 4 * DIGITS
) (
   input  logic         Clk,
   input  logic         RST,
   input  logic         LOAD,
   input  logic [W-1:0] LOAD_VAL,
   input  logic         START,
   input  logic         PAUSE,
   output logic [W-1:0] OUT,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          busy_q, done_q, done_d, err_q, err_d;
   logic          tick;
   logic [W-1:0]  cnt_dec;

   function automatic logic all_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Ripple borrow: a zero digit with borrow-in becomes 9 and passes the borrow on.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick    = (pre_q == PW'(PRESCALE - 1));
   assign cnt_dec = bcd_dec(cnt_q);

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (LOAD) begin
         if (all_bcd(LOAD_VAL)) begin
            cnt_d   = LOAD_VAL;
            state_d = IDLE;
            pre_d   = '0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (START && !PAUSE && cnt_q != '0) begin
                  state_d = RUN;
                  pre_d   = '0;
               end
            end
            RUN: begin
               if (PAUSE) begin
                  state_d = PAUSED;
               end else if (cnt_q == '0) begin
                  state_d = IDLE;
               end else if (tick) begin
                  pre_d = '0;
                  cnt_d = cnt_dec;
                  if (cnt_dec == '0) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            PAUSED: begin
               if (START && !PAUSE) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge Clk) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign OUT  = cnt_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: three instances (2 digits /1, 2 digits /3, 3 digits /1).
// Expected values are hand-computed constants.
module tb_bcd_down_timer;

   logic        Clk = 1'b0;
   logic        RST = 1'b1;

   logic        a_load = 0, a_start = 0, a_pause = 0;
   logic [7:0]  a_val = '0;
   logic [7:0]  a_out;
   logic        a_busy, a_done, a_err;

   logic        b_load = 0, b_start = 0, b_pause = 0;
   logic [7:0]  b_val = '0;
   logic [7:0]  b_out;
   logic        b_busy, b_done, b_err;

   logic        c_load = 0, c_start = 0, c_pause = 0;
   logic [11:0] c_val = '0;
   logic [11:0] c_out;
   logic        c_busy, c_done, c_err;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   bcd_down_timer #(.DIGITS(2), .PRESCALE(1)) u_a (
      .Clk(Clk), .RST(RST), .LOAD(a_load), .LOAD_VAL(a_val), .START(a_start),
      .PAUSE(a_pause), .OUT(a_out), .BUSY(a_busy), .DONE(a_done), .ERR(a_err));

   bcd_down_timer #(.DIGITS(2), .PRESCALE(3)) u_b (
      .Clk(Clk), .RST(RST), .LOAD(b_load), .LOAD_VAL(b_val), .START(b_start),
      .PAUSE(b_pause), .OUT(b_out), .BUSY(b_busy), .DONE(b_done), .ERR(b_err));

   bcd_down_timer #(.DIGITS(3), .PRESCALE(1)) u_c (
      .Clk(Clk), .RST(RST), .LOAD(c_load), .LOAD_VAL(c_val), .START(c_start),
      .PAUSE(c_pause), .OUT(c_out), .BUSY(c_busy), .DONE(c_done), .ERR(c_err));

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] walk [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                             8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

   initial begin
      // reset
      step();
      step();
      RST = 1'b0;
      chk("rst_a_out", a_out, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_b_out", b_out, 0);
      chk("rst_c_out", c_out, 0);

      // 0x12 countdown at full rate
      a_load = 1; a_val = 8'h12;
      step();
      a_load = 0;
      chk("load12_out", a_out, 8'h12);
      chk("load12_busy", a_busy, 0);
      a_start = 1;
      step();
      a_start = 0;
      chk("start_busy", a_busy, 1);
      chk("start_out", a_out, 8'h12);
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("walk_out_%0d", i), a_out, walk[i]);
         chk($sformatf("walk_done_%0d", i), a_done, (i == 11));
         chk($sformatf("walk_busy_%0d", i), a_busy, (i != 11));
      end
      step();
      chk("after_done", a_done, 0);
      chk("after_out", a_out, 0);
      chk("after_busy", a_busy, 0);

      // invalid load, then start from zero
      a_load = 1; a_val = 8'h3A;
      step();
      a_load = 0;
      chk("bad_out", a_out, 0);
      chk("bad_err", a_err, 1);
      step();
      chk("bad_err_clr", a_err, 0);
      a_load = 1; a_val = 8'h00;
      step();
      a_load = 0; a_start = 1;
      step();
      a_start = 0;
      chk("zero_start_busy", a_busy, 0);
      step();
      chk("zero_start_done", a_done, 0);
      chk("zero_start_out", a_out, 0);

      // LOAD aborts a run
      a_load = 1; a_val = 8'h50;
      step();
      a_load = 0; a_start = 1;
      step();
      a_start = 0;
      repeat (5) step();
      chk("run50_out", a_out, 8'h45);
      a_load = 1; a_val = 8'h99;
      step();
      a_load = 0;
      chk("abort_out", a_out, 8'h99);
      chk("abort_busy", a_busy, 0);
      chk("abort_done", a_done, 0);
      step();
      chk("abort_hold", a_out, 8'h99);

      // RST aborts a run
      a_start = 1;
      step();
      a_start = 0;
      repeat (5) step();
      chk("run99_out", a_out, 8'h94);
      RST = 1;
      step();
      RST = 0;
      chk("rst_mid_out", a_out, 0);
      chk("rst_mid_busy", a_busy, 0);
      chk("rst_mid_done", a_done, 0);

      // LOAD on the terminal edge wins over DONE
      a_load = 1; a_val = 8'h02;
      step();
      a_load = 0; a_start = 1;
      step();
      a_start = 0;
      step();
      chk("term_pre", a_out, 8'h01);
      a_load = 1; a_val = 8'h77;
      step();
      a_load = 0;
      chk("term_load_out", a_out, 8'h77);
      chk("term_load_done", a_done, 0);
      chk("term_load_busy", a_busy, 0);

      // prescaler 3 with pause/resume
      b_load = 1; b_val = 8'h05;
      step();
      b_load = 0; b_start = 1;
      step();
      b_start = 0;
      step();
      chk("p3_e1", b_out, 8'h05);
      step();
      chk("p3_e2", b_out, 8'h05);
      step();
      chk("p3_e3", b_out, 8'h04);
      step();
      b_pause = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("p3_pause_out_%0d", i), b_out, 8'h04);
         chk($sformatf("p3_pause_busy_%0d", i), b_busy, 1);
      end
      b_pause = 0; b_start = 1;
      step();
      b_start = 0;
      chk("p3_resume", b_out, 8'h04);
      step();
      chk("p3_resume_1", b_out, 8'h04);
      step();
      chk("p3_resume_2", b_out, 8'h03);
      for (int k = 2; k >= 0; k--) begin
         step();
         step();
         chk($sformatf("p3_hold_%0d", k), b_out, k + 1);
         step();
         chk($sformatf("p3_out_%0d", k), b_out, k);
         chk($sformatf("p3_done_%0d", k), b_done, (k == 0));
      end
      step();
      chk("p3_done_clr", b_done, 0);
      chk("p3_busy_end", b_busy, 0);

      // three digits: full borrow chain, PAUSE beats START
      c_load = 1; c_val = 12'h100;
      step();
      c_load = 0; c_start = 1;
      step();
      c_start = 0;
      step();
      chk("d3_borrow", c_out, 12'h099);
      c_start = 1; c_pause = 1;
      step();
      c_start = 0; c_pause = 0;
      chk("d3_pause_out", c_out, 12'h099);
      chk("d3_pause_busy", c_busy, 1);
      step();
      chk("d3_pause_hold", c_out, 12'h099);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
